// File: rtl/axi_ar_arbiter_if.sv
// rtl/axi_ar_arbiter_if.sv - AR channel bundle: two master request ports, shared slave port, read-data monitor taps
interface axi_ar_arbiter_if #(
   parameter int IDM_BITS  = 4,
   parameter int IDS_BITS  = 8,
   parameter int ADDR_BITS = 32
);
   logic [IDM_BITS-1:0]  ARID_M0,    ARID_M1;
   logic [ADDR_BITS-1:0] ARADDR_M0,  ARADDR_M1;
   logic [3:0]           ARLEN_M0,   ARLEN_M1;
   logic [2:0]           ARSIZE_M0,  ARSIZE_M1;
   logic [1:0]           ARBURST_M0, ARBURST_M1;
   logic                 ARVALID_M0, ARVALID_M1;
   logic                 ARREADY_M0, ARREADY_M1;

   logic [IDS_BITS-1:0]  ARID_S;
   logic [ADDR_BITS-1:0] ARADDR_S;
   logic [3:0]           ARLEN_S;
   logic [2:0]           ARSIZE_S;
   logic [1:0]           ARBURST_S;
   logic                 ARVALID_S;
   logic                 ARREADY_S;

   logic                 RVALID_S, RREADY_S, RLAST_S;
   logic [1:0]           GRANT;

   // Environment view: requesting masters, downstream slave and the R-channel taps
   modport master (
      output ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
             ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
             ARREADY_S, RVALID_S, RREADY_S, RLAST_S,
      input  ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S,
             ARBURST_S, ARVALID_S, GRANT
   );

   // Arbiter view
   modport slave (
      input  ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
             ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1, ARVALID_M0, ARVALID_M1,
             ARREADY_S, RVALID_S, RREADY_S, RLAST_S,
      output ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S,
             ARBURST_S, ARVALID_S, GRANT
   );
endinterface

// File: rtl/axi_ar_arbiter.sv
// rtl/axi_ar_arbiter.sv - two-master AR arbiter holding grant until RLAST; AXI_ARB_FIXED_PRIO_EN selects fixed M0 priority
module axi_ar_arbiter #(
   parameter int IDM_BITS  = 4,
   parameter int IDS_BITS  = 8,
   parameter int ADDR_BITS = 32
) (
   input  logic             ACLK,
   input  logic             ARESETn,
   axi_ar_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

   state_e               state_q, state_d;
   logic [1:0]           grant_q, grant_d;
   logic [IDS_BITS-1:0]  arid_q, arid_d;
   logic [ADDR_BITS-1:0] araddr_q, araddr_d;
   logic [3:0]           arlen_q, arlen_d;
   logic [2:0]           arsize_q, arsize_d;
   logic [1:0]           arburst_q, arburst_d;
   logic                 pick_m1;
   logic                 arready_m0, arready_m1;
   logic                 r_last_hs;

`ifdef AXI_ARB_FIXED_PRIO_EN
   // M0 owns every tie; M1 only gets through when M0 is silent
   always_comb begin
      pick_m1 = ~bus.ARVALID_M0 & bus.ARVALID_M1;
   end
`else
   // 1 means M1 won the previous arbitration; reset value lets M0 win the first tie
   logic last_q, last_d;

   // Round-robin: on a tie the master that did not win last time goes
   always_comb begin
      pick_m1 = bus.ARVALID_M1 & (~bus.ARVALID_M0 | ~last_q);
   end

   // Round-robin history register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) last_q <= 1'b1;
      else          last_q <= last_d;
   end
`endif

   assign r_last_hs = bus.RVALID_S & bus.RREADY_S & bus.RLAST_S;

   // Next state, latched AR fields and the combinational master ARREADY
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      arid_d     = arid_q;
      araddr_d   = araddr_q;
      arlen_d    = arlen_q;
      arsize_d   = arsize_q;
      arburst_d  = arburst_q;
      arready_m0 = 1'b0;
      arready_m1 = 1'b0;
`ifndef AXI_ARB_FIXED_PRIO_EN
      last_d     = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.ARVALID_M0 | bus.ARVALID_M1) begin
               arready_m0 = ~pick_m1;
               arready_m1 = pick_m1;
               if (pick_m1) begin
                  arid_d    = (IDS_BITS'(1) << IDM_BITS) | IDS_BITS'(bus.ARID_M1);
                  araddr_d  = bus.ARADDR_M1;
                  arlen_d   = bus.ARLEN_M1;
                  arsize_d  = bus.ARSIZE_M1;
                  arburst_d = bus.ARBURST_M1;
                  grant_d   = 2'b10;
               end else begin
                  arid_d    = IDS_BITS'(bus.ARID_M0);
                  araddr_d  = bus.ARADDR_M0;
                  arlen_d   = bus.ARLEN_M0;
                  arsize_d  = bus.ARSIZE_M0;
                  arburst_d = bus.ARBURST_M0;
                  grant_d   = 2'b01;
               end
`ifndef AXI_ARB_FIXED_PRIO_EN
               last_d  = pick_m1;
`endif
               state_d = ADDR;
            end
         end
         ADDR: begin
            // RLAST seen here belongs to nobody we track, so it is ignored
            if (bus.ARREADY_S) state_d = DATA;
         end
         DATA: begin
            if (r_last_hs) begin
               state_d = IDLE;
               grant_d = 2'b00;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = 2'b00;
         end
      endcase
   end

   // State and latched slave-side fields
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_q   <= IDLE;
         grant_q   <= 2'b00;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         arid_q    <= arid_d;
         araddr_q  <= araddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
      end
   end

   // ARREADY is forced low while reset is held since IDLE would otherwise accept
   assign bus.ARREADY_M0 = ARESETn & arready_m0;
   assign bus.ARREADY_M1 = ARESETn & arready_m1;
   assign bus.ARVALID_S  = (state_q == ADDR);
   assign bus.ARID_S     = arid_q;
   assign bus.ARADDR_S   = araddr_q;
   assign bus.ARLEN_S    = arlen_q;
   assign bus.ARSIZE_S   = arsize_q;
   assign bus.ARBURST_S  = arburst_q;
   assign bus.GRANT      = grant_q;
endmodule

// File: tb/tb_axi_ar_arbiter.sv
// tb/tb_axi_ar_arbiter.sv - scoreboard bench for axi_ar_arbiter
module tb_axi_ar_arbiter;
   logic clk;
   logic rstn;

   axi_ar_arbiter_if #(.IDM_BITS(4), .IDS_BITS(8), .ADDR_BITS(32)) bus();

   axi_ar_arbiter #(.IDM_BITS(4), .IDS_BITS(8), .ADDR_BITS(32)) dut (
      .ACLK    (clk),
      .ARESETn (rstn),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vectors    = 0;
   int miscompares = 0;

   logic [50:0] exp_q[$];

   // bench-side request state and arbitration model
   logic        v[2];
   logic [3:0]  req_id[2];
   logic [31:0] req_addr[2];
   logic [3:0]  req_len[2];
   logic [2:0]  req_size[2];
   logic [1:0]  req_burst[2];
   int          lw;
   bit          cont;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive_reqs();
      bus.ARVALID_M0 = v[0];        bus.ARVALID_M1 = v[1];
      bus.ARID_M0    = req_id[0];   bus.ARID_M1    = req_id[1];
      bus.ARADDR_M0  = req_addr[0]; bus.ARADDR_M1  = req_addr[1];
      bus.ARLEN_M0   = req_len[0];  bus.ARLEN_M1   = req_len[1];
      bus.ARSIZE_M0  = req_size[0]; bus.ARSIZE_M1  = req_size[1];
      bus.ARBURST_M0 = req_burst[0]; bus.ARBURST_M1 = req_burst[1];
   endtask

   task automatic init_reqs();
      v[0] = 1'b1; req_id[0] = 4'h1; req_addr[0] = 32'h0000_2000; req_len[0] = 4'd1;
      req_size[0] = 3'd2; req_burst[0] = 2'd1;
      v[1] = 1'b1; req_id[1] = 4'h2; req_addr[1] = 32'h0000_3000; req_len[1] = 4'd0;
      req_size[1] = 3'd3; req_burst[1] = 2'd2;
      lw = 1;
   endtask

   function automatic int predict();
      if (v[0] && v[1]) begin
`ifdef AXI_ARB_FIXED_PRIO_EN
         return 0;
`else
         return (lw == 1) ? 0 : 1;
`endif
      end
      return v[1] ? 1 : 0;
   endfunction

   // Called during an IDLE cycle with at least one request driven
   task automatic serve_one(input int stall, input int rstall);
      int          w;
      int          beats;
      logic [1:0]  g;
      logic [7:0]  eid;
      logic [31:0] eaddr;
      #1;
      w     = predict();
      g     = (w == 1) ? 2'b10 : 2'b01;
      eid   = 8'(w * 16 + int'(req_id[w]));
      eaddr = req_addr[w];
      beats = int'(req_len[w]) + 1;
      exp_q.push_back({eid, eaddr, req_len[w], req_size[w], req_burst[w], g});
      chk("arready_winner", (w == 1) ? bus.ARREADY_M1 : bus.ARREADY_M0, 1);
      chk("arready_loser",  (w == 1) ? bus.ARREADY_M0 : bus.ARREADY_M1, 0);
      lw = w;

      @(negedge clk);
      bus.ARREADY_S = (stall == 0);
      if (cont) begin
         req_id[w]   = req_id[w] + 4'd1;
         req_addr[w] = req_addr[w] + 32'h100;
      end else begin
         v[w] = 1'b0;
      end
      drive_reqs();
      #1;
      chk("arvalid_s_addr", bus.ARVALID_S, 1);
      chk("arid_s_addr",    bus.ARID_S, eid);
      chk("grant_addr",     bus.GRANT, g);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (i == stall - 1) bus.ARREADY_S = 1'b1;
         #1;
         chk("arvalid_s_stall", bus.ARVALID_S, 1);
         chk("araddr_stall",    bus.ARADDR_S, eaddr);
         chk("arid_stall",      bus.ARID_S, eid);
         chk("arready_m_stall", {bus.ARREADY_M1, bus.ARREADY_M0}, 2'b00);
      end

      @(negedge clk);
      bus.ARREADY_S = 1'b0;
      #1;
      chk("arvalid_s_data", bus.ARVALID_S, 0);
      chk("grant_data",     bus.GRANT, g);
      for (int i = 0; i < rstall; i++) begin
         bus.RVALID_S = 1'b1; bus.RREADY_S = 1'b0; bus.RLAST_S = 1'b1;
         @(negedge clk);
         #1;
         chk("grant_rready_stall", bus.GRANT, g);
         chk("arready_m_data", {bus.ARREADY_M1, bus.ARREADY_M0}, 2'b00);
      end
      for (int b = 0; b < beats; b++) begin
         bus.RVALID_S = 1'b1; bus.RREADY_S = 1'b1; bus.RLAST_S = (b == beats - 1);
         @(negedge clk);
         #1;
         if (b < beats - 1) chk("grant_beat", bus.GRANT, g);
      end
      bus.RVALID_S = 1'b0; bus.RREADY_S = 1'b0; bus.RLAST_S = 1'b0;
      chk("grant_after_rlast",   bus.GRANT, 2'b00);
      chk("arvalid_after_rlast", bus.ARVALID_S, 0);
   endtask

   // Monitor: every slave-side AR handshake is checked against the scoreboard
   initial begin
      logic [50:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (rstn && bus.ARVALID_S && bus.ARREADY_S) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_ar: got id 0x%0h addr 0x%0h, expected none", bus.ARID_S, bus.ARADDR_S);
            end else begin
               e = exp_q.pop_front();
               chk("ar_xfer", {bus.ARID_S, bus.ARADDR_S, bus.ARLEN_S, bus.ARSIZE_S,
                               bus.ARBURST_S, bus.GRANT}, e);
            end
         end
      end
   end

   initial begin
      rstn = 1'b0;
      cont = 1'b0;
      init_reqs();
      v[0] = 1'b0; v[1] = 1'b0;
      drive_reqs();
      bus.ARREADY_S = 1'b0;
      bus.RVALID_S = 1'b0; bus.RREADY_S = 1'b0; bus.RLAST_S = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      #1;
      chk("rst_grant",   bus.GRANT, 2'b00);
      chk("rst_arvalid", bus.ARVALID_S, 0);
      chk("rst_arready", {bus.ARREADY_M1, bus.ARREADY_M0}, 2'b00);
      chk("rst_arid",    bus.ARID_S, 8'h00);
      chk("rst_araddr",  bus.ARADDR_S, 32'h0);

      // M0 alone, 4-beat burst
      @(negedge clk);
      rstn = 1'b1;
      v[0] = 1'b1; req_id[0] = 4'h5; req_addr[0] = 32'h0000_1000; req_len[0] = 4'd3;
      drive_reqs();
      serve_one(0, 0);
      #1;
      chk("idle_no_req", {bus.ARREADY_M1, bus.ARREADY_M0}, 2'b00);

      // fresh reset, both masters requesting continuously
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      init_reqs();
      cont = 1'b1;
      drive_reqs();
      serve_one(5, 3);
      serve_one(0, 0);
      serve_one(0, 0);

      // reset while in ADDR
      @(negedge clk);
      #1;
      chk("arvalid_pre_reset", bus.ARVALID_S, 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("async_rst_arvalid", bus.ARVALID_S, 0);
      chk("async_rst_grant",   bus.GRANT, 2'b00);
      chk("async_rst_arready", {bus.ARREADY_M1, bus.ARREADY_M0}, 2'b00);
      @(negedge clk);
      init_reqs();
      cont = 1'b0;
      drive_reqs();
      rstn = 1'b1;
      serve_one(0, 0);
      serve_one(0, 1);

      repeat (2) @(negedge clk);
      #1;
      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      chk("final_grant", bus.GRANT, 2'b00);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
